sw_ctrl: RTL and testbench

Run-control front end for the stopwatch digit chain. Takes raw start/stop and clear push-buttons, synchronises and debounces them, and runs an IDLE/RUN/PAUSE state machine. Drives a prescaled one-cycle `tick` into the `ad` input of the least-significant decade-counter cell, a level `stp` into every cell's `stp`, and a one-cycle `clr` used to zero the digit chain.

---
 rtl/sw_ctrl.sv | 135 +++++++++++++
 tb/tb_sw_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_ctrl.sv
// Stopwatch run-control front end: button synchronise/debounce, IDLE/RUN/PAUSE
// state machine, tick prescaler and digit-chain clear pulse.
module sw_ctrl #(
  parameter int DIV        = 500000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_ss,
  input  logic btn_clr,
  output logic tick,
  output logic stp,
  output logic clr,
  output logic running,
  output logic paused
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = $clog2(DIV);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PC_LAST  = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       ss_press;
  logic       clr_press;

  assign btn_raw = {btn_clr, btn_ss};

  // Index 0 is start/stop, index 1 is clear; both paths are identical.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          s1_reg;
      logic          s2_reg;
      logic          deb_reg;
      logic          deb_q_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_reg    <= 1'b0;
          s2_reg    <= 1'b0;
          deb_reg   <= 1'b0;
          deb_q_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          s1_reg    <= btn_raw[gi];
          s2_reg    <= s1_reg;
          deb_q_reg <= deb_reg;
          if (s2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            deb_reg <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign press[gi] = deb_reg & ~deb_q_reg;
    end
  endgenerate

  assign ss_press  = press[0];
  assign clr_press = press[1];

  state_t        state_reg, state_next;
  logic          clr_reg, clr_next;
  logic [PW-1:0] pc_reg, pc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      clr_reg   <= 1'b0;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      clr_reg   <= clr_next;
      pc_reg    <= pc_next;
    end
  end

  // Clear beats start in IDLE/PAUSE; stop beats clear in RUN.
  always_comb begin
    state_next = state_reg;
    clr_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clr_press) begin
          clr_next = 1'b1;
        end else if (ss_press) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ss_press) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (clr_press) begin
          state_next = ST_IDLE;
          clr_next   = 1'b1;
        end else if (ss_press) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // PAUSE holds the fractional period so a restart resumes mid-tick.
  always_comb begin
    pc_next = pc_reg;
    if (state_next == ST_IDLE) begin
      pc_next = '0;
    end else if (state_reg == ST_RUN) begin
      pc_next = (pc_reg == PC_LAST) ? '0 : pc_reg + PW'(1);
    end
  end

  assign tick    = (state_reg == ST_RUN) && (pc_reg == PC_LAST);
  assign stp     = (state_reg != ST_RUN);
  assign running = (state_reg == ST_RUN);
  assign paused  = (state_reg == ST_PAUSE);
  assign clr     = clr_reg;

endmodule

// File: tb/tb_sw_ctrl.sv
// Bench for sw_ctrl: directed scenarios plus random button traffic, checked
// every cycle against a behavioural model of the run-control rules.
module tb_sw_ctrl;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic btn_ss  = 1'b0;
  logic btn_clr = 1'b0;
  logic tick, stp, clr, running, paused;

  int checks     = 0;
  int errors     = 0;
  int clr_pulses = 0;

  sw_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .tick    (tick),
    .stp     (stp),
    .clr     (clr),
    .running (running),
    .paused  (paused)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;
  mstate_t m_state;
  int      m_runs;          // RUN cycles accumulated since last IDLE
  bit      m_clr;
  bit      m_deb [2];
  bit      m_debq[2];
  bit      hist0[$];        // raw samples, newest first
  bit      hist1[$];

  // A level is accepted once the synchronised input has shown the opposite
  // level for DEB consecutive cycles (synchronised = raw two edges back).
  function automatic bit flips(input bit h[$], input bit level);
    for (int i = 1; i <= DEB; i++)
      if (h[i] == level) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_runs  = 0;
    m_clr   = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_deb[b]  = 1'b0;
      m_debq[b] = 1'b0;
    end
    hist0.delete();
    hist1.delete();
    repeat (DEB + 2) begin
      hist0.push_back(1'b0);
      hist1.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit p_ss, p_clr;
    p_ss  = m_deb[0] && !m_debq[0];
    p_clr = m_deb[1] && !m_debq[1];
    m_debq[0] = m_deb[0];
    m_debq[1] = m_deb[1];
    if (flips(hist0, m_deb[0])) m_deb[0] = !m_deb[0];
    if (flips(hist1, m_deb[1])) m_deb[1] = !m_deb[1];
    hist0.push_front(btn_ss);
    hist1.push_front(btn_clr);
    void'(hist0.pop_back());
    void'(hist1.pop_back());
    m_clr = 1'b0;
    case (m_state)
      M_IDLE: begin
        if (p_clr) m_clr = 1'b1;
        else if (p_ss) m_state = M_RUN;
      end
      M_RUN: begin
        m_runs++;
        if (p_ss) m_state = M_PAUSE;
      end
      default: begin
        if (p_clr) begin
          m_state = M_IDLE;
          m_clr   = 1'b1;
          m_runs  = 0;
        end else if (p_ss) begin
          m_state = M_RUN;
        end
      end
    endcase
  endtask

  initial model_reset();

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  always @(negedge clk) begin
    check("tick",    tick,    (m_state == M_RUN) && ((m_runs % DIV) == DIV - 1));
    check("stp",     stp,     m_state != M_RUN);
    check("clr",     clr,     m_clr);
    check("running", running, m_state == M_RUN);
    check("paused",  paused,  m_state == M_PAUSE);
    check("tick_and_stp", tick & stp, 1'b0);
    if (clr === 1'b1) clr_pulses++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit which_clr, input int len);
    if (which_clr) btn_clr = 1'b1; else btn_ss = 1'b1;
    repeat (len) step();
    btn_clr = 1'b0;
    btn_ss  = 1'b0;
  endtask

  // Hold start/stop, measure edges to RUN and then edges to the first tick.
  task automatic restart(input string name, input int exp_tick_edges);
    int n, m;
    btn_ss = 1'b1;
    n = 0;
    while (!running && n < 30) begin step(); n++; end
    check_int({name, "_run_latency"}, n, DEB + 3);
    m = 0;
    while (!tick && m < 30) begin step(); m++; end
    if (exp_tick_edges >= 0) check_int({name, "_tick_latency"}, m, exp_tick_edges);
    repeat (4) step();
    btn_ss = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    int base, n;
    repeat (3) step();
    check("rst_stp", stp, 1'b1);
    check("rst_tick", tick, 1'b0);
    check("rst_clr", clr, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_paused", paused, 1'b0);
    reset = 1'b0;

    // First start: stp falls at edge 6, ticks at edges 9, 13, 17.
    step();
    btn_ss = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      check("start_stp", stp, (e >= 6) ? 1'b0 : 1'b1);
      check("start_tick", tick, (e == 9 || e == 13 || e == 17) ? 1'b1 : 1'b0);
      if (e == 10) btn_ss = 1'b0;
    end

    // Two-cycle glitch must be rejected.
    pulse(1'b0, 2);
    repeat (10) step();
    check("glitch_running", running, 1'b1);

    // Pause one edge after a tick so the held fraction is 2 of 4.
    n = 0;
    while (!tick && n < 20) begin step(); n++; end
    check("find_tick", tick, 1'b1);
    step();
    pulse(1'b0, 10);
    repeat (6) step();
    check("pause_paused", paused, 1'b1);
    check("pause_stp", stp, 1'b1);
    check("pause_tick", tick, 1'b0);
    restart("resume", 1);

    // Clear while running is ignored.
    base = clr_pulses;
    pulse(1'b1, 10);
    repeat (6) step();
    check_int("run_clr_pulses", clr_pulses - base, 0);
    check("run_clr_running", running, 1'b1);

    // Pause, then clear back to IDLE.
    pulse(1'b0, 10);
    repeat (6) step();
    check("pause2_paused", paused, 1'b1);
    base = clr_pulses;
    pulse(1'b1, 10);
    repeat (6) step();
    check_int("pause_clr_pulses", clr_pulses - base, 1);
    check("idle_running", running, 1'b0);
    check("idle_paused", paused, 1'b0);
    restart("from_idle", DIV - 1);

    // Simultaneous presses: stop wins in RUN, clear wins in PAUSE.
    base = clr_pulses;
    btn_ss = 1'b1; btn_clr = 1'b1;
    repeat (10) step();
    btn_ss = 1'b0; btn_clr = 1'b0;
    repeat (6) step();
    check("both_run_paused", paused, 1'b1);
    check_int("both_run_clr", clr_pulses - base, 0);
    base = clr_pulses;
    btn_ss = 1'b1; btn_clr = 1'b1;
    repeat (10) step();
    btn_ss = 1'b0; btn_clr = 1'b0;
    repeat (6) step();
    check("both_pause_running", running, 1'b0);
    check("both_pause_paused", paused, 1'b0);
    check_int("both_pause_clr", clr_pulses - base, 1);

    // Long hold gives one event; release gives none; re-press gives another.
    pulse(1'b0, 100);
    repeat (20) step();
    check("hold_running", running, 1'b1);
    pulse(1'b0, 10);
    repeat (6) step();
    check("repress_paused", paused, 1'b1);

    // Asynchronous reset mid-RUN with start held through release.
    btn_ss = 1'b1;
    n = 0;
    while (!running && n < 30) begin step(); n++; end
    check("pre_reset_running", running, 1'b1);
    step();
    #1 reset = 1'b1;
    #1;
    check("async_stp", stp, 1'b1);
    check("async_tick", tick, 1'b0);
    check("async_running", running, 1'b0);
    #1 reset = 1'b0;
    n = 0;
    while (!running && n < 30) begin step(); n++; end
    check_int("post_reset_latency", n, DEB + 3);
    btn_ss = 1'b0;
    repeat (10) step();

    // Random button traffic with bounces and occasional resets.
    for (int i = 0; i < 250; i++) begin
      btn_ss  = 1'($urandom_range(0, 1));
      btn_clr = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 14)) begin
        step();
        if ($urandom_range(0, 199) == 0) begin
          #1 reset = 1'b1;
          #2 reset = 1'b0;
        end
      end
    end
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
